// File: rtl/peripheral_msi_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_msi_apb_arbiter
// Description : Two-master round-robin APB4 arbiter in front of the single
//               APB port of the MSI peripheral. Each master sees an ordinary
//               APB slave that stretches its access phase while the arbiter
//               runs that master's transfer on the shared slave port. A
//               wait-state watchdog aborts a stalled slave transfer with
//               PSLVERR so a hung slave cannot lock out both masters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   mN_PSEL/PENABLE/PADDR/
//   PWDATA/PWRITE   (in)    APB request from master N (N = 0, 1)
//   mN_PRDATA/PREADY/
//   PSLVERR         (out)   APB response to master N
//   s_PSEL/PENABLE/PWRITE/
//   PADDR/PWDATA    (out)   shared slave request (registered)
//   s_PRDATA/PREADY/
//   PSLVERR         (in)    shared slave response
//   grant_o         (out)   master owning the slave, valid while busy_o = 1
//   busy_o          (out)   arbiter is running a slave transfer
// ============================================================================
module peripheral_msi_apb_arbiter #(
  parameter int APB_ADDR_WIDTH = 8,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      m0_PSEL,
  input  logic                      m0_PENABLE,
  input  logic [APB_ADDR_WIDTH-1:0] m0_PADDR,
  input  logic [APB_DATA_WIDTH-1:0] m0_PWDATA,
  input  logic                      m0_PWRITE,
  output logic [APB_DATA_WIDTH-1:0] m0_PRDATA,
  output logic                      m0_PREADY,
  output logic                      m0_PSLVERR,
  input  logic                      m1_PSEL,
  input  logic                      m1_PENABLE,
  input  logic [APB_ADDR_WIDTH-1:0] m1_PADDR,
  input  logic [APB_DATA_WIDTH-1:0] m1_PWDATA,
  input  logic                      m1_PWRITE,
  output logic [APB_DATA_WIDTH-1:0] m1_PRDATA,
  output logic                      m1_PREADY,
  output logic                      m1_PSLVERR,
  output logic                      s_PSEL,
  output logic                      s_PENABLE,
  output logic                      s_PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] s_PADDR,
  output logic [APB_DATA_WIDTH-1:0] s_PWDATA,
  input  logic [APB_DATA_WIDTH-1:0] s_PRDATA,
  input  logic                      s_PREADY,
  input  logic                      s_PSLVERR,
  output logic                      grant_o,
  output logic                      busy_o
);

  // A zero TIMEOUT disables the watchdog; keep the counter one bit wide then.
  localparam int                 c_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
  localparam logic               c_WDOG_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                    r_state;
  logic                      r_grant;
  logic                      r_last;     // master granted most recently
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_write;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic [c_CNT_W-1:0]        r_cnt;

  logic                      w_in_access;
  logic                      w_expired;
  logic                      w_done;
  logic                      w_idle_win;
  logic                      w_other_req;
  logic                      w_start;
  logic                      w_next;
  logic                      w_rsp0;
  logic                      w_rsp1;
  logic [APB_DATA_WIDTH-1:0] w_rsp_data;
  logic                      w_rsp_err;

  assign w_in_access = (r_state == ST_ACCESS);
  assign w_expired   = c_WDOG_EN && (r_cnt == c_TIMEOUT);
  // A real slave response takes precedence over a watchdog abort.
  assign w_done      = w_in_access && (s_PREADY || w_expired);

  // From IDLE: a lone requester wins, otherwise the one not granted last.
  assign w_idle_win  = (m0_PSEL && m1_PSEL) ? ~r_last : m1_PSEL;
  // On completion only the other master may take over without an IDLE bubble.
  assign w_other_req = r_grant ? m0_PSEL : m1_PSEL;
  assign w_start     = ((r_state == ST_IDLE) && (m0_PSEL || m1_PSEL)) ||
                       (w_done && w_other_req);
  assign w_next      = w_in_access ? ~r_grant : w_idle_win;

  // An aborted transfer reports an error with zeroed read data.
  assign w_rsp_data  = s_PREADY ? s_PRDATA : '0;
  assign w_rsp_err   = s_PREADY ? s_PSLVERR : 1'b1;

  // A master that left its access phase early gets no response.
  assign w_rsp0      = w_done && !r_grant && m0_PSEL && m0_PENABLE;
  assign w_rsp1      = w_done &&  r_grant && m1_PSEL && m1_PENABLE;

  assign m0_PREADY   = w_rsp0;
  assign m0_PRDATA   = w_rsp0 ? w_rsp_data : '0;
  assign m0_PSLVERR  = w_rsp0 && w_rsp_err;
  assign m1_PREADY   = w_rsp1;
  assign m1_PRDATA   = w_rsp1 ? w_rsp_data : '0;
  assign m1_PSLVERR  = w_rsp1 && w_rsp_err;

  assign s_PSEL      = r_psel;
  assign s_PENABLE   = r_penable;
  assign s_PWRITE    = r_write;
  assign s_PADDR     = r_addr;
  assign s_PWDATA    = r_wdata;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state != ST_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        ST_ACCESS: begin
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A new grant overrides the completion path above.
      if (w_start) begin
        r_state   <= ST_SETUP;
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_grant   <= w_next;
        r_last    <= w_next;
        r_addr    <= w_next ? m1_PADDR  : m0_PADDR;
        r_wdata   <= w_next ? m1_PWDATA : m0_PWDATA;
        r_write   <= w_next ? m1_PWRITE : m0_PWRITE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_msi_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_msi_apb_arbiter
// Description : Self-checking bench for peripheral_msi_apb_arbiter. Two APB
//               master drivers and a memory-backed slave with per-address
//               wait states surround the arbiter; completions are checked
//               against transfer-level predictions (serving order, completion
//               cycle, read data from a reference memory, slave-side view).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_msi_apb_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          m0_PSEL, m0_PENABLE, m0_PWRITE, m0_PREADY, m0_PSLVERR;
  logic [AW-1:0] m0_PADDR;
  logic [DW-1:0] m0_PWDATA, m0_PRDATA;
  logic          m1_PSEL, m1_PENABLE, m1_PWRITE, m1_PREADY, m1_PSLVERR;
  logic [AW-1:0] m1_PADDR;
  logic [DW-1:0] m1_PWDATA, m1_PRDATA;
  logic          s_PSEL, s_PENABLE, s_PWRITE, s_PREADY, s_PSLVERR;
  logic [AW-1:0] s_PADDR;
  logic [DW-1:0] s_PWDATA, s_PRDATA;
  logic          grant_o, busy_o;

  always #5 HCLK = ~HCLK;

  peripheral_msi_apb_arbiter #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_PSEL(m0_PSEL), .m0_PENABLE(m0_PENABLE), .m0_PADDR(m0_PADDR),
    .m0_PWDATA(m0_PWDATA), .m0_PWRITE(m0_PWRITE), .m0_PRDATA(m0_PRDATA),
    .m0_PREADY(m0_PREADY), .m0_PSLVERR(m0_PSLVERR),
    .m1_PSEL(m1_PSEL), .m1_PENABLE(m1_PENABLE), .m1_PADDR(m1_PADDR),
    .m1_PWDATA(m1_PWDATA), .m1_PWRITE(m1_PWRITE), .m1_PRDATA(m1_PRDATA),
    .m1_PREADY(m1_PREADY), .m1_PSLVERR(m1_PSLVERR),
    .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
    .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA), .s_PRDATA(s_PRDATA),
    .s_PREADY(s_PREADY), .s_PSLVERR(s_PSLVERR),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        write;
    int          exp_done;   // cycle in which the master must see PREADY
    logic        abort;      // expect a watchdog abort instead of a slave reply
  } xact_t;

  int          n_err = 0;
  int          n_chk = 0;
  int          cyc   = 0;
  int          last  = 1;    // master served most recently (reset: 1)
  logic [31:0] ref_mem [256];
  logic [31:0] sl_mem  [256];
  int          wait_tab[256];
  logic        err_tab [256];
  xact_t       q0[$], q1[$], st0[$], st1[$];
  xact_t       cur[2];
  int          phase[2];     // 0 idle, 1 setup, 2 access
  logic [40:0] slog[$];
  logic [40:0] snap;
  int          sl_acc = 0;
  logic        sl_stuck = 1'b0;
  int          order_log[$], exp_order[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=0x%0h required=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pending();
    return q0.size() + q1.size() + phase[0] + phase[1];
  endfunction

  function automatic xact_t rand_xact();
    xact_t x;
    x.addr     = 8'($urandom_range(0, 255));
    x.wdata    = $urandom;
    x.write    = 1'($urandom_range(0, 1));
    x.exp_done = 0;
    x.abort    = 1'b0;
    return x;
  endfunction

  task automatic drive_pins(input int m);
    if (m == 0) begin
      m0_PSEL = (phase[0] != 0); m0_PENABLE = (phase[0] == 2);
      m0_PADDR = cur[0].addr; m0_PWDATA = cur[0].wdata; m0_PWRITE = cur[0].write;
    end else begin
      m1_PSEL = (phase[1] != 0); m1_PENABLE = (phase[1] == 2);
      m1_PADDR = cur[1].addr; m1_PWDATA = cur[1].wdata; m1_PWRITE = cur[1].write;
    end
  endtask

  task automatic master_drive(input int m);
    if (phase[m] == 0) begin
      if (m == 0 && q0.size() > 0) begin
        cur[0] = q0.pop_front(); phase[0] = 1;
      end else if (m == 1 && q1.size() > 0) begin
        cur[1] = q1.pop_front(); phase[1] = 1;
      end
    end else if (phase[m] == 1) begin
      phase[m] = 2;
    end
    drive_pins(m);
  endtask

  // Memory-backed slave; wait states and error response depend on the address.
  task automatic slave_drive();
    s_PREADY = 1'b0; s_PRDATA = $urandom; s_PSLVERR = 1'($urandom_range(0, 1));
    if (s_PSEL && !s_PENABLE) begin
      snap = {s_PWRITE, s_PADDR, s_PWDATA};
      sl_acc = 0;
    end else if (s_PSEL && s_PENABLE) begin
      if (!sl_stuck && sl_acc >= wait_tab[s_PADDR]) begin
        s_PREADY  = 1'b1;
        s_PSLVERR = err_tab[s_PADDR];
        if (!s_PWRITE) s_PRDATA = sl_mem[s_PADDR];
        check_eq("slave_req_stable", 64'({s_PWRITE, s_PADDR, s_PWDATA}), 64'(snap));
        slog.push_back({s_PWRITE, s_PADDR, s_PWDATA});
        if (s_PWRITE) sl_mem[s_PADDR] = s_PWDATA;
        sl_acc = 0;
      end else begin
        sl_acc++;
      end
    end else begin
      sl_acc = 0;
    end
  endtask

  task automatic complete(input int m, input logic [31:0] rd, input logic er);
    xact_t       x;
    logic [40:0] s;
    x = cur[m];
    check_eq("done_cycle", 64'(cyc), 64'(x.exp_done));
    check_eq("grant_busy", 64'({busy_o, grant_o}), 64'({1'b1, 1'(m)}));
    if (x.abort) begin
      check_eq("abort_resp", 64'({er, rd}), 64'({1'b1, 32'd0}));
    end else begin
      if (slog.size() == 0) begin
        check_eq("slave_xfer_seen", 64'(slog.size()), 64'd1);
      end else begin
        s = slog.pop_front();
        check_eq("slave_xfer", 64'(s), 64'({x.write, x.addr, x.wdata}));
      end
      check_eq("slverr", 64'(er), 64'(err_tab[x.addr]));
      if (x.write) ref_mem[x.addr] = x.wdata;
      else         check_eq("rdata", 64'(rd), 64'(ref_mem[x.addr]));
    end
    order_log.push_back(m);
    last     = m;
    phase[m] = 0;
  endtask

  task automatic monitor();
    logic        rdy, er;
    logic [31:0] rd;
    for (int m = 0; m < 2; m++) begin
      rdy = (m == 0) ? m0_PREADY  : m1_PREADY;
      rd  = (m == 0) ? m0_PRDATA  : m1_PRDATA;
      er  = (m == 0) ? m0_PSLVERR : m1_PSLVERR;
      if (rdy) begin
        if (phase[m] == 2) complete(m, rd, er);
        else               check_eq("spurious_ready", 64'(rdy), 64'd0);
      end else if (rd != 0 || er) begin
        check_eq("idle_resp", 64'({rd, er}), 64'd0);
      end
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    cyc++;
    #1;
    slave_drive();
    master_drive(0);
    master_drive(1);
    @(negedge HCLK);
    monitor();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq("run_complete", 64'(pending()), 64'd0);
    if (pending() != 0) begin
      q0.delete(); q1.delete(); phase[0] = 0; phase[1] = 0;
      drive_pins(0); drive_pins(1);
    end
    step();
    check_eq("idle_after_run", 64'({busy_o, s_PSEL}), 64'd0);
  endtask

  // Schedules the staged transfers and predicts, transfer by transfer, who is
  // served and when: a hand-off to the other master costs 2 + waits cycles
  // after the previous completion, the same master again costs 3 + waits
  // (it passes through IDLE), the first one 2 + waits after the request.
  task automatic traffic();
    int    n   = st0.size() + st1.size();
    int    t   = cyc + 1;
    int    prev = -1;
    int    mm;
    xact_t x;
    exp_order.delete(); order_log.delete();
    while (st0.size() + st1.size() > 0) begin
      if (st0.size() > 0 && st1.size() > 0) mm = (prev < 0) ? (1 - last) : (1 - prev);
      else                                  mm = (st0.size() > 0) ? 0 : 1;
      if (mm == 0) x = st0.pop_front();
      else         x = st1.pop_front();
      t = t + ((prev < 0) ? 2 : ((mm == prev) ? 3 : 2)) + wait_tab[x.addr];
      x.exp_done = t;
      if (mm == 0) q0.push_back(x);
      else         q1.push_back(x);
      exp_order.push_back(mm);
      prev = mm;
    end
    run(40 + 12 * n);
    check_eq("order_len", 64'(order_log.size()), 64'(exp_order.size()));
    for (int k = 0; k < exp_order.size() && k < order_log.size(); k++)
      check_eq("serve_order", 64'(order_log[k]), 64'(exp_order[k]));
  endtask

  initial begin
    xact_t x;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = $urandom;
      sl_mem[i]   = ref_mem[i];
      wait_tab[i] = $urandom_range(0, 3);
      err_tab[i]  = ($urandom_range(0, 7) == 0);
    end
    for (int m = 0; m < 2; m++) begin
      cur[m] = '{addr: 8'd0, wdata: 32'd0, write: 1'b0, exp_done: 0, abort: 1'b0};
      phase[m] = 0;
      drive_pins(m);
    end
    s_PREADY = 1'b0; s_PRDATA = '0; s_PSLVERR = 1'b0;

    // Reset state
    repeat (3) step();
    check_eq("reset_ctrl", 64'({s_PSEL, s_PENABLE, s_PWRITE, busy_o, grant_o,
                                m0_PREADY, m0_PSLVERR, m1_PREADY, m1_PSLVERR}), 64'd0);
    check_eq("reset_bus", 64'({s_PADDR, s_PWDATA}), 64'd0);
    check_eq("reset_rdata", {m0_PRDATA, m1_PRDATA}, 64'd0);
    HRESETn = 1'b1;
    last    = 1;

    // Contention from reset: m0 write 0x10<-0x11 first, then m1 0x14<-0x22
    st0.push_back('{addr: 8'h10, wdata: 32'h11, write: 1'b1, exp_done: 0, abort: 1'b0});
    st1.push_back('{addr: 8'h14, wdata: 32'h22, write: 1'b1, exp_done: 0, abort: 1'b0});
    traffic();

    // Single zero-wait read of 0x04 returning 0xA5A5_0001
    wait_tab[4] = 0; err_tab[4] = 1'b0;
    ref_mem[4] = 32'hA5A5_0001; sl_mem[4] = 32'hA5A5_0001;
    st0.push_back('{addr: 8'h04, wdata: 32'h0, write: 1'b0, exp_done: 0, abort: 1'b0});
    traffic();

    // m1 write through three slave wait states
    wait_tab[8'h20] = 3;
    st1.push_back('{addr: 8'h20, wdata: $urandom, write: 1'b1, exp_done: 0, abort: 1'b0});
    traffic();

    // Random single transfers
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) st0.push_back(rand_xact());
      else                           st1.push_back(rand_xact());
      traffic();
    end

    // Random simultaneous contention
    for (int i = 0; i < 4; i++) begin
      st0.push_back(rand_xact());
      st1.push_back(rand_xact());
      traffic();
    end

    // One master streaming alone, then both streaming back-to-back
    for (int i = 0; i < 3; i++) st1.push_back(rand_xact());
    traffic();
    for (int i = 0; i < 4; i++) begin
      x = rand_xact(); x.write = 1'b0; st0.push_back(x);
      x = rand_xact(); x.write = 1'b0; st1.push_back(x);
    end
    traffic();

    // Watchdog abort on a stuck slave, then a normal m1 transfer
    sl_stuck = 1'b1;
    x = rand_xact(); x.write = 1'b0; x.abort = 1'b1;
    x.exp_done = cyc + 1 + 2 + TMO;
    order_log.delete();
    q0.push_back(x);
    run(40);
    sl_stuck = 1'b0;
    st1.push_back(rand_xact());
    traffic();

    // Reset during ACCESS of an m0 transfer
    sl_stuck = 1'b1;
    x = rand_xact(); x.exp_done = -1;
    q0.push_back(x);
    repeat (4) step();
    check_eq("pre_reset_access", 64'({busy_o, s_PSEL, s_PENABLE, grant_o}), 64'b1110);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("async_reset_ctrl", 64'({s_PSEL, s_PENABLE, s_PWRITE, busy_o, grant_o,
                                      m0_PREADY, m0_PSLVERR, m1_PREADY, m1_PSLVERR}), 64'd0);
    check_eq("async_reset_bus", 64'({s_PADDR, s_PWDATA}), 64'd0);
    check_eq("async_reset_rdata", {m0_PRDATA, m1_PRDATA}, 64'd0);
    q0.delete(); q1.delete(); slog.delete();
    phase[0] = 0; phase[1] = 0;
    drive_pins(0); drive_pins(1);
    sl_stuck = 1'b0;
    last     = 1;
    step(); step();
    HRESETn = 1'b1;

    // First contention after reset must go to m0 again
    st0.push_back(rand_xact());
    st1.push_back(rand_xact());
    traffic();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peripheral_msi_apb_arbiter.md
# peripheral_msi_apb_arbiter

Two-master round-robin APB4 arbiter that shares the single APB port of the MSI peripheral between the AHB3-to-APB bridge and a second APB requester, such as a DMA or debug master. Each master sees a standard APB slave that inserts wait states while the arbiter runs that master's transfer on the shared slave port. The arbiter includes a slave-stall watchdog, so a hung slave cannot lock out both masters.

## Interface
- APB_ADDR_WIDTH, 8, address width on all ports
- APB_DATA_WIDTH, 32, data width on all ports
- TIMEOUT, 255, maximum slave wait-state cycles before the transfer is aborted with error; 0 disables the watchdog
- HCLK  in  1  single clock; every register updates on the rising edge
- HRESETn  in  1  asynchronous active-low reset
- mN_PSEL  in  1  master N select (N=0,1)
- mN_PENABLE  in  1  master N access phase
- mN_PADDR  in  APB_ADDR_WIDTH  master N address
- mN_PWDATA  in  APB_DATA_WIDTH  master N write data
- mN_PWRITE  in  1  master N direction, 1=write
- mN_PRDATA  out  APB_DATA_WIDTH  read data to master N
- mN_PREADY  out  1  transfer complete to master N
- mN_PSLVERR  out  1  error to master N
- s_PSEL, s_PENABLE, s_PWRITE  out  1  shared-slave control
- s_PADDR  out  APB_ADDR_WIDTH  shared-slave address
- s_PWDATA  out  APB_DATA_WIDTH  shared-slave write data
- s_PRDATA  in  APB_DATA_WIDTH  shared-slave read data
- s_PREADY, s_PSLVERR  in  1  shared-slave response
- grant_o  out  1  index of the master currently owning the slave; valid while busy_o=1
- busy_o  out  1  FSM is not in IDLE

## Operation
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE:**
  - Request from master N = mN_PSEL=1.
  - With any request, choose the winner and register it: the winner's PADDR/PWDATA/PWRITE are latched and grant_o is updated.
  - Then go to SETUP.
- **Round robin:**
  - With one request, that master wins.
  - With both requesting, the master not granted last wins.
  - The last-granted pointer resets to 1, so m0 wins the first contention.
- **SETUP:**
  - Outputs: s_PSEL=1, s_PENABLE=0, plus the latched address, data and direction.
  - Always moves to ACCESS after one cycle.
- **ACCESS:**
  - Outputs: s_PSEL=1, s_PENABLE=1.
  - When s_PREADY=1, combinationally forward s_PREADY, s_PRDATA and s_PSLVERR to the granted master for that cycle only; the transfer completes.
- **After completion:**
  - If the other master has PSEL=1, grant it, latch its signals and go directly to SETUP (no IDLE bubble).
  - Otherwise go to IDLE.
  - The master that just completed never wins this hand-off.
- **Non-granted master:** PREADY=0, PRDATA=0, PSLVERR=0. Its request stays pending, because APB holds PSEL and signals stable until PREADY.
- **Watchdog:**
  - The counter, $clog2(TIMEOUT+1) bits wide, clears on entry to ACCESS and increments each ACCESS cycle with s_PREADY=0.
  - When the count equals TIMEOUT and s_PREADY=0, abort: granted master gets PREADY=1, PSLVERR=1, PRDATA=0 that cycle, and the FSM leaves ACCESS as on normal completion.
  - If s_PREADY=1 in the same cycle, normal completion wins.
- **Master drops PSEL mid-transfer (protocol violation):** the slave transfer runs to completion and the response is discarded. The pointer still updates.
- **Write/read data:** no byte manipulation; widths are passed through unchanged.

## Timing
- **Reset values (asynchronous, immediate):**
  - All s_* outputs, mN_PRDATA, mN_PREADY, mN_PSLVERR, busy_o and grant_o = 0.
  - FSM = IDLE, pointer = 1, counter = 0.
- **Reset asserted mid-transfer:** the slave transfer is abandoned at once and no response is given.
- **Minimum latency:**
  - Master setup at cycle T; slave SETUP at T+1; slave ACCESS at T+2.
  - With a zero-wait slave, master PREADY=1 at T+2, i.e. one master wait state.
- **Slave wait states** add 1:1 to master wait states.
- **Back-to-back contention:** m1's slave SETUP starts the cycle after m0's completion cycle.
- **s_PADDR/s_PWDATA/s_PWRITE** are registered and stable from SETUP through the completion cycle.

## Test plan
- **Single read:** m0 reads 0x04 and the slave returns 0xA5A5_0001 with zero waits → s_PSEL at T+1, s_PENABLE at T+2, m0_PREADY=1 and m0_PRDATA=0xA5A5_0001 at T+2; m1_PREADY stays 0.
- **Contention from reset:** m0 writes 0x10←0x11 and m1 writes 0x14←0x22 in the same cycle → slave sees 0x10/0x11, then 0x14/0x22 with no IDLE cycle between; grant_o goes 0 then 1.
- **Fairness:** both masters issue continuous back-to-back reads for 8 transfers → grants strictly alternate 0,1,0,1…; no master waits more than one transfer.
- **Slave wait states:** s_PREADY held low for 3 ACCESS cycles while m1 writes → m1_PREADY=1 exactly on the fourth ACCESS cycle; s_PWDATA is stable throughout.
- **Timeout:** with TIMEOUT=4 and s_PREADY stuck at 0 → m0_PREADY=1, m0_PSLVERR=1, m0_PRDATA=0 on the fifth ACCESS cycle; s_PSEL=0 the next cycle. A pending m1 request is then served normally.
- **Reset mid-ACCESS:** HRESETn low during ACCESS → all outputs 0 immediately, busy_o=0. After release, the first contention is won by m0.
